// File: rtl/axi_wr_master_pkg.sv
// Shared encodings, FSM state type and command legality check for the AXI3 write initiator.
// No ports; imported by axi_wr_master and axi_wr_master_wbuf.
package axi_wr_master_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, CHECK, XFER, RESP, DONE} state_t;

    // Bit positions inside rsp_flags = {timeout, bid_mismatch, rejected}
    localparam int unsigned FLAG_REJECTED     = 0;
    localparam int unsigned FLAG_BID_MISMATCH = 1;
    localparam int unsigned FLAG_TIMEOUT      = 2;

    // Only the low 12 address bits matter: they decide WRAP alignment and 4KB crossing.
    function automatic logic cmd_legal(input logic [11:0] addr, input logic [3:0] len,
                                       input logic [2:0] size, input logic [1:0] burst,
                                       input int unsigned strb_w);
        logic        ok;
        logic [12:0] nbytes;
        logic [12:0] end_addr;
        logic [11:0] mask;
        ok       = 1'b1;
        nbytes   = ({9'd0, len} + 13'd1) << size;
        end_addr = {1'b0, addr} + nbytes;
        mask     = ~(12'hFFF << size);
        if (burst == 2'b11) ok = 1'b0;
        // 2^size > strb_w is the same as size > log2(strb_w) for power-of-two strb_w
        if ((32'd1 << size) > strb_w) ok = 1'b0;
        if (burst == BURST_WRAP) begin
            if (!(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) ok = 1'b0;
            if ((addr & mask) != 12'd0) ok = 1'b0;
        end
        if (burst == BURST_INCR && end_addr > 13'd4096) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/axi_wr_master_wbuf.sv
// Single-entry W channel output register with beat counter and WLAST generation.
// Ports: start/len/id arm a burst; wd_* is the local beat stream; W* drive the AXI W channel;
// w_last_hs flags the final WLAST handshake this cycle, w_done holds it until the next start.
module axi_wr_master_wbuf
    import axi_wr_master_pkg::*;
#(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        len,
    input  logic [ID_W-1:0]   id,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    input  logic [STRB_W-1:0] wd_strb,
    output logic [ID_W-1:0]   WID,
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    output logic              w_last_hs,
    output logic              w_done
);

    logic [3:0] cnt_q;
    logic       loading_q;   // beats still to be taken from wd_*
    logic       wd_hs;

    // Accept a new beat when the register is empty or is being drained this cycle
    assign wd_ready  = loading_q && (!WVALID || WREADY);
    assign wd_hs     = wd_valid && wd_ready;
    assign w_last_hs = WVALID && WREADY && WLAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            loading_q <= 1'b0;
            w_done    <= 1'b0;
            WID       <= '0;
            WDATA     <= '0;
            WSTRB     <= '0;
            WLAST     <= 1'b0;
            WVALID    <= 1'b0;
        end else if (start) begin
            cnt_q     <= len;
            loading_q <= 1'b1;
            w_done    <= 1'b0;
        end else begin
            if (wd_hs) begin
                WDATA  <= wd_data;
                WSTRB  <= wd_strb;
                WID    <= id;
                WVALID <= 1'b1;
                WLAST  <= (cnt_q == 4'd0);
                if (cnt_q == 4'd0) loading_q <= 1'b0;
                else               cnt_q     <= cnt_q - 4'd1;
            end else if (WREADY) begin
                WVALID <= 1'b0;
                WLAST  <= 1'b0;
            end
            if (w_last_hs) w_done <= 1'b1;
        end
    end

endmodule

// File: rtl/axi_wr_master.sv
// AXI3 write-channel initiator: takes one burst command plus its beats, drives AW/W/B and
// returns one response per command; one transaction outstanding at a time.
// Ports: cmd_* command in, wd_* beat stream in, rsp_* response out, AW*/W*/B* AXI3 master side.
module axi_wr_master
    import axi_wr_master_pkg::*;
#(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned B_TIMEOUT = 256,
    localparam int unsigned STRB_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    input  logic [STRB_W-1:0] wd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [1:0]        rsp_resp,
    output logic [2:0]        rsp_flags,
    output logic [ID_W-1:0]   AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [3:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [ID_W-1:0]   WID,
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [ID_W-1:0]   BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);

    localparam int unsigned TMO_W = (B_TIMEOUT > 2) ? $clog2(B_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((B_TIMEOUT == 0) ? 0 : B_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              aw_done_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              legal, aw_hs, xfer_end, tmo_hit, w_last_hs, w_done, wb_start;

    assign legal    = cmd_legal(addr_q[11:0], len_q, size_q, burst_q, STRB_W);
    assign aw_hs    = AWVALID && AWREADY;
    // Either channel may finish first, or both in the same cycle
    assign xfer_end = (aw_done_q || aw_hs) && (w_done || w_last_hs);
    assign tmo_hit  = (B_TIMEOUT != 0) && (tmo_q == TMO_LAST);
    assign wb_start = (state_q == CHECK) && legal;

    axi_wr_master_wbuf #(
        .ID_W   (ID_W),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .start     (wb_start),
        .len       (len_q),
        .id        (id_q),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .wd_strb   (wd_strb),
        .WID       (WID),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .w_last_hs (w_last_hs),
        .w_done    (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = CHECK;
            CHECK:   state_d = legal ? XFER : DONE;
            XFER:    if (xfer_end) state_d = RESP;
            RESP:    if (BVALID || tmo_hit) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cmd_ready stays low while reset is held even though the state is IDLE
    always_comb begin
        cmd_ready = (state_q == IDLE) && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            aw_done_q <= 1'b0;
            tmo_q     <= '0;
            AWID      <= '0;
            AWADDR    <= '0;
            AWLEN     <= '0;
            AWSIZE    <= '0;
            AWBURST   <= '0;
            AWVALID   <= 1'b0;
            BREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_resp  <= '0;
            rsp_flags <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (cmd_valid) begin
                    id_q    <= cmd_id;
                    addr_q  <= cmd_addr;
                    len_q   <= cmd_len;
                    size_q  <= cmd_size;
                    burst_q <= cmd_burst;
                end
                CHECK: begin
                    if (legal) begin
                        AWID      <= id_q;
                        AWADDR    <= addr_q;
                        AWLEN     <= len_q;
                        AWSIZE    <= size_q;
                        AWBURST   <= burst_q;
                        AWVALID   <= 1'b1;
                        aw_done_q <= 1'b0;
                    end else begin
                        rsp_valid                <= 1'b1;
                        rsp_id                   <= id_q;
                        rsp_resp                 <= RESP_SLVERR;
                        rsp_flags                <= '0;
                        rsp_flags[FLAG_REJECTED] <= 1'b1;
                    end
                end
                XFER: begin
                    if (aw_hs) begin
                        AWVALID   <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (xfer_end) begin
                        BREADY <= 1'b1;
                        tmo_q  <= '0;
                    end
                end
                RESP: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    // BVALID wins over a coincident timeout
                    if (BVALID) begin
                        BREADY                       <= 1'b0;
                        rsp_valid                    <= 1'b1;
                        rsp_id                       <= id_q;
                        rsp_resp                     <= BRESP;
                        rsp_flags                    <= '0;
                        rsp_flags[FLAG_BID_MISMATCH] <= (BID != id_q);
                    end else if (tmo_hit) begin
                        BREADY                  <= 1'b0;
                        rsp_valid               <= 1'b1;
                        rsp_id                  <= id_q;
                        rsp_resp                <= RESP_SLVERR;
                        rsp_flags               <= '0;
                        rsp_flags[FLAG_TIMEOUT] <= 1'b1;
                    end
                end
                DONE: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_master.sv
module tb_axi_wr_master;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        logic        accept;
        logic [1:0]  resp;
        logic [2:0]  flags;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
        logic [2:0] flags;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [3:0]  cmd_id = '0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic        wd_valid = 1'b0, wd_ready;
    logic [31:0] wd_data = '0;
    logic [3:0]  wd_strb = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [3:0]  rsp_id;
    logic [1:0]  rsp_resp;
    logic [2:0]  rsp_flags;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY = 1'b0;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY = 1'b0;
    logic [3:0]  BID = '0;
    logic [1:0]  BRESP = '0;
    logic        BVALID = 1'b0, BREADY;

    int checks = 0;
    int errors = 0;

    // Slave policy, written by the main sequence
    int         aw_delay = 0;
    logic       w_toggle = 1'b0;
    logic       b_never = 1'b0;
    logic [3:0] b_id = '0;
    logic [1:0] b_resp = '0;
    logic [44:0] exp_aw = '0;

    // Monitor state and cumulative counters
    int   aw_wait = 0, aw_hs_cnt = 0, w_hs_cnt = 0, awv_cnt = 0, wv_cnt = 0;
    int   bready_cnt = 0, rsp_cnt = 0;
    logic aw_seen = 0, wl_seen = 0, b_given = 0, b_hs = 0;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];
    vec_t  vecs[11];

    axi_wr_master #(
        .ID_W      (4),
        .ADDR_W    (32),
        .DATA_W    (32),
        .B_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_id    (cmd_id),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .cmd_burst (cmd_burst),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .wd_strb   (wd_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_resp  (rsp_resp),
        .rsp_flags (rsp_flags),
        .AWID      (AWID),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWBURST   (AWBURST),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WID       (WID),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model plus monitor: inputs change on the falling edge, handshakes that the next
    // rising edge will see are evaluated 2 time units later once everything has settled.
    always @(negedge clk) begin
        if (rst) begin
            AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
            aw_wait = 0; aw_seen = 0; wl_seen = 0; b_given = 0; b_hs = 0;
        end else begin
            AWREADY = (aw_delay == 0) ? 1'b1 : (AWVALID && aw_wait >= aw_delay);
            if (AWVALID) aw_wait++;
            else         aw_wait = 0;
            WREADY = w_toggle ? ~WREADY : 1'b1;
            if (b_hs) begin
                BVALID = 1'b0;
                b_hs   = 1'b0;
            end else if (aw_seen && wl_seen && !b_never && !b_given) begin
                BVALID  = 1'b1;
                BID     = b_id;
                BRESP   = b_resp;
                b_given = 1'b1;
            end
        end
        #2;
        if (!rst) begin
            if (AWVALID) begin
                awv_cnt++;
                chk("aw_stable", {AWID, AWADDR, AWLEN, AWSIZE, AWBURST}, exp_aw);
            end
            if (WVALID) wv_cnt++;
            if (AWVALID && AWREADY) begin
                aw_seen = 1'b1;
                aw_hs_cnt++;
            end
            if (WVALID && WREADY) begin
                w_hs_cnt++;
                chk("w_expected", beat_q.size() > 0, 1);
                if (beat_q.size() > 0) begin
                    beat_t e;
                    e = beat_q.pop_front();
                    chk("w_beat", {WID, WLAST, WSTRB, WDATA}, {e.id, e.last, e.strb, e.data});
                end
                if (WLAST) wl_seen = 1'b1;
            end
            if (BREADY) begin
                bready_cnt++;
                chk("bready_after_both", aw_seen && wl_seen, 1);
            end
            if (BVALID && BREADY) b_hs = 1'b1;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", rsp_q.size() > 0, 1);
                if (rsp_q.size() > 0) begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp", {rsp_id, rsp_resp, rsp_flags}, {r.id, r.resp, r.flags});
                end
                rsp_cnt++;
                aw_seen = 1'b0; wl_seen = 1'b0; b_given = 1'b0;
            end
        end
    end

    // All tasks start and return on a falling edge
    task automatic send_cmd(input vec_t v);
        bit got = 0;
        exp_aw    = {v.id, v.addr, v.len, v.size, v.burst};
        cmd_valid = 1'b1; cmd_id = v.id; cmd_addr = v.addr;
        cmd_len   = v.len; cmd_size = v.size; cmd_burst = v.burst;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (cmd_ready) got = 1;
            @(negedge clk);
            if (got) break;
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", got, 1);
    endtask

    task automatic send_beats(input int nbeats, input logic [3:0] len, input logic [3:0] id);
        for (int b = 0; b < nbeats; b++) begin
            bit got = 0;
            wd_valid = 1'b1;
            wd_data  = $urandom;
            wd_strb  = 4'($urandom_range(1, 15));
            for (int i = 0; i < 100; i++) begin
                #2;
                if (wd_ready) begin
                    got = 1;
                    beat_q.push_back('{wd_data, wd_strb, (b == int'(len)), id});
                end
                @(negedge clk);
                if (got) break;
            end
            chk("wd_accepted", got, 1);
            if (!got) break;
        end
        wd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int r0);
        for (int i = 0; i < 400; i++) begin
            if (rsp_cnt != r0) break;
            @(negedge clk);
        end
        chk("rsp_arrived", rsp_cnt != r0, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int aw0, awv0, wv0, w0, r0;
        aw0 = aw_hs_cnt; awv0 = awv_cnt; wv0 = wv_cnt; w0 = w_hs_cnt; r0 = rsp_cnt;
        b_id = v.bid; b_resp = v.bresp;
        rsp_q.push_back('{v.id, v.resp, v.flags});
        send_cmd(v);
        if (v.accept) send_beats(int'(v.len) + 1, v.len, v.id);
        wait_rsp(r0);
        if (v.accept) begin
            chk("aw_hs_once", aw_hs_cnt - aw0, 1);
            chk("w_hs_count", w_hs_cnt - w0, int'(v.len) + 1);
            chk("beats_drained", beat_q.size(), 0);
        end else begin
            chk("no_awvalid", awv_cnt - awv0, 0);
            chk("no_wvalid", wv_cnt - wv0, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        int   r0, b0;
        //            id     addr        len   size  burst  bid   bresp acc   resp   flags
        vecs[0]  = '{4'd3, 32'h100,  4'd3,  3'd2, 2'b01, 4'd3, 2'b00, 1'b1, 2'b00, 3'b000};
        vecs[1]  = '{4'd1, 32'h104,  4'd2,  3'd2, 2'b10, 4'd1, 2'b00, 1'b0, 2'b10, 3'b001};
        vecs[2]  = '{4'd2, 32'hFF8,  4'd3,  3'd2, 2'b01, 4'd2, 2'b00, 1'b0, 2'b10, 3'b001};
        vecs[3]  = '{4'd2, 32'hFF0,  4'd3,  3'd2, 2'b01, 4'd2, 2'b00, 1'b1, 2'b00, 3'b000};
        vecs[4]  = '{4'd4, 32'h000,  4'd0,  3'd2, 2'b11, 4'd4, 2'b00, 1'b0, 2'b10, 3'b001};
        vecs[5]  = '{4'd5, 32'h000,  4'd0,  3'd3, 2'b01, 4'd5, 2'b00, 1'b0, 2'b10, 3'b001};
        vecs[6]  = '{4'd6, 32'h108,  4'd3,  3'd2, 2'b10, 4'd6, 2'b01, 1'b1, 2'b01, 3'b000};
        vecs[7]  = '{4'd7, 32'h102,  4'd1,  3'd2, 2'b10, 4'd7, 2'b00, 1'b0, 2'b10, 3'b001};
        vecs[8]  = '{4'd8, 32'hFFC,  4'd15, 3'd2, 2'b00, 4'd8, 2'b11, 1'b1, 2'b11, 3'b000};
        vecs[9]  = '{4'd9, 32'hFFF,  4'd0,  3'd0, 2'b01, 4'd9, 2'b00, 1'b1, 2'b00, 3'b000};
        vecs[10] = '{4'd3, 32'h200,  4'd1,  3'd2, 2'b01, 4'd5, 2'b10, 1'b1, 2'b10, 3'b010};

        // Reset state
        #3;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wd_ready", wd_ready, 0);
        chk("rst_valids", {AWVALID, WVALID, WLAST, BREADY, rsp_valid}, 0);
        chk("rst_payload", {AWADDR, WDATA, rsp_id, rsp_resp, rsp_flags}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #2;
        chk("idle_cmd_ready", cmd_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // AW held off 5 cycles, WREADY toggling, 8 beats, response held by rsp_ready=0
        aw_delay = 5; w_toggle = 1'b1; rsp_ready = 1'b0;
        b_id = 4'd10; b_resp = 2'b00;
        v = '{4'd10, 32'h400, 4'd7, 3'd2, 2'b01, 4'd10, 2'b00, 1'b1, 2'b00, 3'b000};
        b0 = aw_hs_cnt; r0 = w_hs_cnt;
        rsp_q.push_back('{v.id, v.resp, v.flags});
        send_cmd(v);
        send_beats(8, v.len, v.id);
        for (int i = 0; i < 200; i++) begin
            #2;
            if (rsp_valid) break;
            @(negedge clk);
        end
        chk("stall_rsp_valid", rsp_valid, 1);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("stall_rsp_held", {rsp_valid, cmd_ready, rsp_id}, {1'b1, 1'b0, 4'd10});
        r0 = rsp_cnt;
        rsp_ready = 1'b1;
        wait_rsp(r0);
        chk("stall_aw_hs", aw_hs_cnt - b0, 1);
        chk("stall_beats_drained", beat_q.size(), 0);
        @(negedge clk);
        aw_delay = 0; w_toggle = 1'b0;

        // BVALID never comes: timeout after 16 cycles in RESP
        b_never = 1'b1;
        v = '{4'd3, 32'h500, 4'd1, 3'd2, 2'b01, 4'd3, 2'b00, 1'b1, 2'b10, 3'b100};
        b0 = bready_cnt;
        run_vec(v);
        chk("timeout_resp_cycles", bready_cnt - b0, 16);
        b_never = 1'b0;

        // Asynchronous reset in the middle of a burst, after 2 of 4 beats
        aw_delay = 30;
        v = '{4'd2, 32'h300, 4'd3, 3'd2, 2'b01, 4'd2, 2'b00, 1'b1, 2'b00, 3'b000};
        r0 = rsp_cnt;
        send_cmd(v);
        send_beats(2, v.len, v.id);
        #3;
        chk("pre_rst_awvalid", AWVALID, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {AWVALID, WVALID, BREADY, rsp_valid, wd_ready, cmd_ready}, 0);
        @(negedge clk); @(negedge clk);
        beat_q.delete();
        aw_delay = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("no_rsp_after_rst", rsp_cnt - r0, 0);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
